// File: rtl/pin_id_uart_fmt_pkg.sv
// pin_id_pkg: shared constants and encodings for the pin-ID UART formatter.
//   ASCII byte constants, the A..Z letter index encoding used by the blink
//   stages, the formatter FSM state encoding and the byte-select enumeration.
package pin_id_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_AT    = 8'h40;  // 'A' - 1, so letter = AT + index

  // Row letter index: 1=A .. 26=Z, 0 and anything above 26 are invalid.
  typedef enum logic [6:0] {
    LTR_NONE = 7'd0,
    LTR_A = 7'd1,  LTR_B = 7'd2,  LTR_C = 7'd3,  LTR_D = 7'd4,  LTR_E = 7'd5,
    LTR_F = 7'd6,  LTR_G = 7'd7,  LTR_H = 7'd8,  LTR_I = 7'd9,  LTR_J = 7'd10,
    LTR_K = 7'd11, LTR_L = 7'd12, LTR_M = 7'd13, LTR_N = 7'd14, LTR_O = 7'd15,
    LTR_P = 7'd16, LTR_Q = 7'd17, LTR_R = 7'd18, LTR_S = 7'd19, LTR_T = 7'd20,
    LTR_U = 7'd21, LTR_V = 7'd22, LTR_W = 7'd23, LTR_X = 7'd24, LTR_Y = 7'd25,
    LTR_Z = 7'd26
  } letter_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SPLIT, ST_SEND, ST_WAIT} fmt_state_e;

  typedef enum logic [2:0] {SEL_LETTER, SEL_TENS, SEL_ONES, SEL_CR, SEL_LF} byte_sel_e;

  // Decimal digit to ASCII; out-of-range columns print '?' instead.
  function automatic logic [7:0] digit_char(input logic [3:0] d, input logic oor);
    return oor ? ASCII_QMARK : (ASCII_0 + {4'h0, d});
  endfunction

endpackage

// File: rtl/pin_id_uart_fmt_if.sv
// pin_id_uart_fmt_if: formatter <-> uart_tx byte handshake plus message status.
//   tx_byte_o  : byte to send, stable from send until done
//   tx_send_o  : one-cycle send request
//   tx_done_i  : one-cycle pulse when uart_tx finished the byte
//   busy_o     : message in progress
//   msg_done_o : one-cycle pulse when the whole message is out
// master = formatter side, slave = uart_tx / observer side.
interface pin_id_uart_fmt_if;
  logic [7:0] tx_byte_o;
  logic       tx_send_o;
  logic       tx_done_i;
  logic       busy_o;
  logic       msg_done_o;

  modport master (output tx_byte_o, tx_send_o, busy_o, msg_done_o, input tx_done_i);
  modport slave  (input tx_byte_o, tx_send_o, busy_o, msg_done_o, output tx_done_i);
endinterface

// File: rtl/pin_id_uart_fmt_dec_split.sv
// dec_split: splits a COL_W-bit value into decimal tens/ones by repeated
// subtraction of 10.
//   start : load value (one cycle)
//   done  : high while the result is ready (comb, until the unit goes idle)
//   tens/ones : digits, held until the next start
//   oor   : value > 99; digits are meaningless then
// Worst case (99) is done 9 cycles after the loading edge.
module dec_split #(
  parameter int COL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] value,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             oor
);

  logic             active;
  logic [COL_W-1:0] rem;
  logic [3:0]       tens_q;
  logic             oor_q;

  // Out-of-range values finish immediately; the digits are not used.
  assign done = active && (oor_q || (rem < COL_W'(10)));
  assign tens = tens_q;
  assign ones = rem[3:0];
  assign oor  = oor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      rem    <= '0;
      tens_q <= '0;
      oor_q  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      rem    <= value;
      tens_q <= '0;
      oor_q  <= (value > COL_W'(99));
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        rem    <= rem - COL_W'(10);
        tens_q <= tens_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pin_id_uart_fmt.sv
// pin_id_uart_fmt: once per PERIOD cycles (when enabled) captures a pin ID and
// sends "<letter><number>\r\n" byte by byte over the uart_tx send/done
// handshake.
//   clk_i, rst_i : clock, async active-high reset
//   enable_i     : gates new messages only; a running message completes
//   row_i        : letter index 1..26 (else '?')
//   col_i        : ball number 0..99 (else "??"), leading zero suppressed
//   bus          : tx byte/send/done handshake, busy and msg_done status
module pin_id_uart_fmt
  import pin_id_pkg::*;
#(
  parameter int PERIOD = 25000000,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  pin_id_uart_fmt_if.master bus
);

  localparam int CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  fmt_state_e       state, state_n;
  byte_sel_e        sel, sel_n;
  logic [ROW_W-1:0] row_q;
  logic [7:0]       tx_byte, byte_n, letter_byte;
  logic             msg_done_q, msg_done_n;
  logic             capture;
  logic             split_done, oor;
  logic [3:0]       tens, ones;

  // Free-running period counter, independent of enable_i.
  assign tick = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // The msg_done cycle still counts as busy, so a tick landing there is dropped.
  assign capture = (state == ST_IDLE) && tick && enable_i && !msg_done_q;

  // The column is captured inside the splitter on the same edge as the row.
  dec_split #(.COL_W(COL_W)) u_split (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (capture),
    .value (col_i),
    .done  (split_done),
    .tens  (tens),
    .ones  (ones),
    .oor   (oor)
  );

  assign letter_byte = (row_q >= ROW_W'(LTR_A) && row_q <= ROW_W'(LTR_Z))
                       ? (ASCII_AT + 8'(row_q)) : ASCII_QMARK;

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    msg_done_n = 1'b0;
    case (state)
      ST_IDLE:  if (capture) state_n = ST_SPLIT;
      ST_SPLIT: begin
        if (split_done) begin
          state_n = ST_SEND;
          sel_n   = SEL_LETTER;
        end
      end
      ST_SEND:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done_i) begin
          state_n = ST_SEND;
          case (sel)
            // Tens digit is skipped for single-digit columns, but "??" needs both slots.
            SEL_LETTER: sel_n = (oor || tens != 4'd0) ? SEL_TENS : SEL_ONES;
            SEL_TENS:   sel_n = SEL_ONES;
            SEL_ONES:   sel_n = SEL_CR;
            SEL_CR:     sel_n = SEL_LF;
            default: begin
              state_n    = ST_IDLE;
              msg_done_n = 1'b1;
            end
          endcase
        end
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_n = ASCII_LF;
    case (sel_n)
      SEL_LETTER: byte_n = letter_byte;
      SEL_TENS:   byte_n = digit_char(tens, oor);
      SEL_ONES:   byte_n = digit_char(ones, oor);
      SEL_CR:     byte_n = ASCII_CR;
      default:    byte_n = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      sel        <= SEL_LETTER;
      row_q      <= '0;
      tx_byte    <= 8'h00;
      msg_done_q <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      msg_done_q <= msg_done_n;
      if (capture) row_q <= row_i;
      // Byte is loaded only on entry to SEND, so it holds through WAIT.
      if (state_n == ST_SEND) tx_byte <= byte_n;
    end
  end

  assign bus.tx_byte_o  = tx_byte;
  assign bus.tx_send_o  = (state == ST_SEND);
  assign bus.busy_o     = (state != ST_IDLE) || msg_done_q;
  assign bus.msg_done_o = msg_done_q;

endmodule

// File: tb/tb_pin_id_uart_fmt.sv
module tb_pin_id_uart_fmt;

  localparam int PERIOD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] row = '0;
  logic [6:0] col = '0;

  pin_id_uart_fmt_if u();

  pin_id_uart_fmt #(.PERIOD(PERIOD), .ROW_W(7), .COL_W(7)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .row_i    (row),
    .col_i    (col),
    .bus      (u)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         send_cnt = 0;
  int         msg_cnt = 0;
  int         dly = 5;
  int         stray_cnt = 0;
  logic       outst;
  logic [7:0] last_byte;
  logic       prev_send;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // uart_tx model: tx_done_i pulses dly cycles after a send; aborts on reset.
  initial begin : uart_model
    int n;
    int seen;
    seen = 0;
    u.tx_done_i = 1'b0;
    @(posedge clk); #1;
    forever begin
      if (!rst && u.tx_send_o) begin
        n = 0;
        while (n < dly && !rst) begin
          @(posedge clk); #1;
          n++;
        end
        if (!rst) begin
          u.tx_done_i = 1'b1;
          @(posedge clk); #1;
          u.tx_done_i = 1'b0;
        end
      end else if (stray_cnt != seen) begin
        seen++;
        u.tx_done_i = 1'b1;
        @(posedge clk); #1;
        u.tx_done_i = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: pops the scoreboard on every send, checks hold and message end.
  initial begin : monitor
    outst = 1'b0;
    prev_send = 1'b0;
    last_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        outst = 1'b0;
        prev_send = 1'b0;
      end else begin
        if (u.tx_send_o) begin
          chk("send_gap", prev_send, 0);
          send_cnt++;
          chk("send_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("tx_byte", u.tx_byte_o, exp_q.pop_front());
          last_byte = u.tx_byte_o;
          outst = 1'b1;
        end
        if (u.tx_done_i && outst) begin
          chk("byte_hold", u.tx_byte_o, last_byte);
          outst = 1'b0;
        end
        if (u.msg_done_o) begin
          chk("msg_busy", u.busy_o, 1);
          chk("msg_last_lf", last_byte, 8'h0A);
          msg_cnt++;
        end
        prev_send = u.tx_send_o;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_msgs(input int target, input int budget);
    int k;
    k = 0;
    while (msg_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("msg_timeout", msg_cnt >= target, 1);
  endtask

  task automatic push(input int n, input logic [39:0] b);
    for (int i = 0; i < n; i++) exp_q.push_back(b[39-8*i -: 8]);
  endtask

  task automatic do_msg(input int r, input int c, input int nmsg, input int n,
                        input logic [39:0] b, input int budget);
    int base;
    int target;
    base = send_cnt;
    target = msg_cnt + nmsg;
    row = 7'(r);
    col = 7'(c);
    for (int m = 0; m < nmsg; m++) push(n, b);
    enable = 1'b1;
    wait_msgs(target, budget);
    enable = 1'b0;
    chk("send_count", send_cnt - base, n * nmsg);
    cycles(1);
    chk("busy_after", u.busy_o, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int target;
    int k;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx_byte", u.tx_byte_o, 8'h00);
    chk("rst_tx_send", u.tx_send_o, 0);
    chk("rst_busy", u.busy_o, 0);
    chk("rst_msg_done", u.msg_done_o, 0);
    cycles(3);
    rst = 1'b0;

    do_msg(20, 6,   1, 4, {8'h54, 8'h36, 8'h0D, 8'h0A, 8'h00}, 200);
    do_msg(14, 13,  2, 5, {8'h4E, 8'h31, 8'h33, 8'h0D, 8'h0A}, 300);
    do_msg(0,  100, 1, 5, {8'h3F, 8'h3F, 8'h3F, 8'h0D, 8'h0A}, 200);
    do_msg(27, 0,   1, 4, {8'h3F, 8'h30, 8'h0D, 8'h0A, 8'h00}, 200);

    // Slow uart: several ticks fall inside the message and must be dropped.
    dly = 100;
    do_msg(1, 5, 1, 4, {8'h41, 8'h35, 8'h0D, 8'h0A, 8'h00}, 1000);
    dly = 5;

    // Stray done while idle.
    base = send_cnt;
    stray_cnt++;
    cycles(10);
    chk("stray_no_send", send_cnt - base, 0);
    chk("stray_idle", u.busy_o, 0);

    // Disabled across several ticks.
    base = send_cnt;
    cycles(200);
    chk("disabled_no_send", send_cnt - base, 0);

    // Enable dropped mid-message: message completes, nothing follows.
    base = send_cnt;
    row = 7'd3;
    col = 7'd99;
    push(5, {8'h43, 8'h39, 8'h39, 8'h0D, 8'h0A});
    target = msg_cnt + 1;
    enable = 1'b1;
    k = 0;
    while (!u.busy_o && k < 100) begin
      cycles(1);
      k++;
    end
    chk("busy_rise", u.busy_o, 1);
    enable = 1'b0;
    wait_msgs(target, 200);
    cycles(200);
    chk("drop_en_count", send_cnt - base, 5);

    // Reset while waiting on the ONES byte.
    base = send_cnt;
    row = 7'd14;
    col = 7'd13;
    push(3, {8'h4E, 8'h31, 8'h33, 8'h00, 8'h00});
    enable = 1'b1;
    k = 0;
    while (send_cnt < base + 3 && k < 200) begin
      cycles(1);
      k++;
    end
    chk("reach_ones", send_cnt - base, 3);
    cycles(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_byte", u.tx_byte_o, 8'h00);
    chk("mid_rst_tx_send", u.tx_send_o, 0);
    chk("mid_rst_busy", u.busy_o, 0);
    chk("mid_rst_msg_done", u.msg_done_o, 0);
    chk("mid_rst_queue", exp_q.size(), 0);
    row = 7'd2;
    col = 7'd42;
    push(5, {8'h42, 8'h34, 8'h32, 8'h0D, 8'h0A});
    cycles(3);
    rst = 1'b0;
    base = send_cnt;
    cycles(60);
    chk("no_send_before_tick", send_cnt - base, 0);
    target = msg_cnt + 1;
    wait_msgs(target, 200);
    enable = 1'b0;
    chk("post_rst_count", send_cnt - base, 5);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pin_id_uart_fmt.md
Name: pin_id_uart_fmt

Overview:
- Message formatter that sits directly upstream of uart_tx in the pin-scan design.
- Takes a pin ID (row letter index plus ball number, the same encoding the blink stages use) and periodically emits the ASCII string "<letter><number>\r\n" one byte at a time over the uart_tx send/txed handshake.
- Lets the bench PC log which ball is currently under test, alongside the LED blink pattern.

Parameters:
- PERIOD, 25000000, clk_i cycles between message starts (1 s at 25 MHz); minimum 16.
- ROW_W, 7, width of row index input (matches blink letter encoding).
- COL_W, 7, width of ball number input.

Ports:
- clk_i  input  1  system clock (25 MHz).
- rst_i  input  1  reset; asynchronous, active-high.
- enable_i  input  1  when low, no new message starts; a message in progress completes.
- row_i  input  ROW_W  letter index; 1=A … 26=Z.
- col_i  input  COL_W  ball number, 0..99 valid.
- tx_byte_o  output  8  byte to uart_tx.
- tx_send_o  output  1  one-cycle request to uart_tx.
- tx_done_i  input  1  one-cycle pulse from uart_tx when a byte has finished.
- busy_o  output  1  high while a message is in progress.
- msg_done_o  output  1  one-cycle pulse after the LF byte's tx_done_i.

Behaviour:
- Reset values: tx_byte_o=0x00, tx_send_o=0, busy_o=0, msg_done_o=0, period counter=0, FSM=IDLE.
- Period counter: free-running 0..PERIOD-1, wraps to 0. A "tick" is the cycle in which the counter equals PERIOD-1. The counter runs regardless of enable_i.
- IDLE: on a tick with enable_i=1, capture row_i and col_i into internal registers and go to SPLIT. Inputs are not sampled at any other time. A tick that arrives while busy is dropped; ticks are never queued.
- SPLIT: split the captured column into tens and ones digits (0..9 each); latency of at most 10 cycles. Then go to LETTER.
- Byte mapping:
  - Letter: row 1..26 maps to 0x40+row; any other row value maps to '?' (0x3F).
  - Number, col ≤ 99: tens digit sent as 0x30+tens only when tens≠0; ones digit always sent as 0x30+ones.
  - Number, col > 99: sent as "??" (0x3F 0x3F).
  - Terminator: 0x0D then 0x0A.
- Per-byte handshake, identical for LETTER, TENS, ONES, CR and LF:
  - In the SEND cycle, drive tx_byte_o and pulse tx_send_o high for exactly one cycle.
  - Move to WAIT. tx_byte_o holds stable until tx_done_i is seen.
  - In WAIT, tx_done_i advances to the next byte's SEND on the following cycle.
  - tx_done_i in any state other than WAIT is ignored.
  - There is no timeout.
- After the LF byte's tx_done_i: pulse msg_done_o for one cycle, drop busy_o, return to IDLE.
- busy_o is high from the cycle after capture through the cycle msg_done_o is pulsed.
- enable_i falling mid-message has no effect on the message in progress.
- Asserting rst_i at any point, including mid-byte, returns all state to reset values immediately. A partially sent message is abandoned and not resumed.
- tx_send_o is never high in two consecutive cycles.

Decomposition:
- Package pin_id_pkg: ASCII constants (ASCII_0, ASCII_QMARK, ASCII_CR, ASCII_LF, ASCII_AT), letter index constants A..Z (1..26), and the FSM state encoding (IDLE, SPLIT, SEND, WAIT) plus the byte-select enumeration (LETTER, TENS, ONES, CR, LF).
- One sub-module: dec_split.
  - Splits a COL_W-bit value into tens and ones digits by iterative subtraction of 10.
  - start/done handshake; out-of-range flag set for values > 99.

Test Plan:
- PERIOD=64, row=20 (T), col=6; uart model returns tx_done_i 5 cycles after each send -> bytes 0x54,0x36,0x0D,0x0A; exactly 4 send pulses; msg_done_o pulses once.
- row=14 (N), col=13 -> 0x4E,0x31,0x33,0x0D,0x0A; next tick repeats the identical sequence.
- row=0, col=100 -> 0x3F,0x3F,0x3F,0x0D,0x0A; row=27, col=0 -> 0x3F,0x30,0x0D,0x0A.
- uart model delays tx_done_i by 100 cycles (longer than PERIOD) -> ticks during busy are dropped; tx_byte_o stays stable while waiting; no extra send pulses; stray tx_done_i during IDLE is ignored.
- enable_i=0 across several ticks -> no tx_send_o. Drop enable_i mid-message -> the message completes and no further message starts.
- Assert rst_i during the WAIT for the ONES byte -> all outputs return to reset values immediately. After release, the first message starts on the next tick with a fresh capture and no partial bytes.
